// File: rtl/cmd_sched_queue.sv
// Command FIFO plus one-at-a-time scheduler that feeds pulse-pack commands to master_start.
// Build option: define STALE_DROP_EN to drop and count commands whose TIME_START leaves too little lead.
//
// state     | meaning
// WAIT_FIFO | idle, waiting for a queued command
// POP       | head entry moves into the holding register
// CHECK     | lead-time test on the held command
// ISSUE     | WR_DATA pulse, MEM_* loaded from the holding register
// ARMED     | waiting for master_start to start the command
// RUN       | waiting for master_start to finish the command
module cmd_sched_queue #(
  parameter int DEPTH       = 8,
  parameter int LEAD_CYCLES = 96
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   FLUSH,
  input  logic                   CMD_WR,
  input  logic [47:0]            CMD_DDS_freq,
  input  logic [47:0]            CMD_DDS_delta_freq,
  input  logic [31:0]            CMD_DDS_delta_rate,
  input  logic [63:0]            CMD_TIME_START,
  input  logic [15:0]            CMD_N_impuls,
  input  logic [1:0]             CMD_TYPE_impulse,
  input  logic [31:0]            CMD_Interval_Ti,
  input  logic [31:0]            CMD_Interval_Tp,
  input  logic [31:0]            CMD_Tblank1,
  input  logic [31:0]            CMD_Tblank2,
  input  logic [63:0]            TIME,
  input  logic                   REQ_COMMAND,
  output logic                   WR_DATA,
  output logic [47:0]            MEM_DDS_freq,
  output logic [47:0]            MEM_DDS_delta_freq,
  output logic [31:0]            MEM_DDS_delta_rate,
  output logic [63:0]            MEM_TIME_START,
  output logic [15:0]            MEM_N_impuls,
  output logic [1:0]             MEM_TYPE_impulse,
  output logic [31:0]            MEM_Interval_Ti,
  output logic [31:0]            MEM_Interval_Tp,
  output logic [31:0]            MEM_Tblank1,
  output logic [31:0]            MEM_Tblank2,
  output logic                   FULL,
  output logic                   EMPTY,
  output logic [$clog2(DEPTH):0] LEVEL,
  output logic                   OVF,
  output logic [15:0]            DROP_CNT,
  output logic                   BUSY
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [47:0] dds_freq;
    logic [47:0] dds_delta_freq;
    logic [31:0] dds_delta_rate;
    logic [63:0] time_start;
    logic [15:0] n_impuls;
    logic [1:0]  type_impulse;
    logic [31:0] interval_ti;
    logic [31:0] interval_tp;
    logic [31:0] tblank1;
    logic [31:0] tblank2;
  } cmd_t;

  typedef enum logic [2:0] {
    S_WAIT_FIFO,
    S_POP,
    S_CHECK,
    S_ISSUE,
    S_ARMED,
    S_RUN
  } state_t;

  cmd_t          cmd_in;
  cmd_t          hold_r;
  cmd_t          mem_out_r;
  cmd_t          fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_r;
  logic [LW-1:0] level_nxt;
  logic          full_r;
  logic          empty_r;
  logic          ovf_r;
  logic          wr_data_r;
  logic          req_q;
  logic          req_q2;
  logic          req_rise;
  logic          req_fall;
  logic          push;
  logic          pop;
  state_t        state;

  assign cmd_in = {CMD_DDS_freq, CMD_DDS_delta_freq, CMD_DDS_delta_rate, CMD_TIME_START,
                   CMD_N_impuls, CMD_TYPE_impulse, CMD_Interval_Ti, CMD_Interval_Tp,
                   CMD_Tblank1, CMD_Tblank2};

  // A write into a full queue is still taken when the scheduler pops the head that same cycle.
  assign pop  = (state == S_POP);
  assign push = CMD_WR && !FLUSH && (!full_r || pop);

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= cmd_in;
  end

  always_comb begin
    level_nxt = level_r;
    if (push && !pop)      level_nxt = level_r + LW'(1);
    else if (pop && !push) level_nxt = level_r - LW'(1);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_r <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      ovf_r   <= 1'b0;
    end else if (FLUSH) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_r <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      ovf_r   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level_r <= level_nxt;
      full_r  <= (level_nxt == LW'(DEPTH));
      empty_r <= (level_nxt == '0);
      if (CMD_WR && full_r && !pop) ovf_r <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      req_q  <= 1'b0;
      req_q2 <= 1'b0;
    end else begin
      req_q  <= REQ_COMMAND;
      req_q2 <= req_q;
    end
  end

  assign req_rise = req_q && !req_q2;
  assign req_fall = !req_q && req_q2;

`ifdef STALE_DROP_EN
  logic [15:0] drop_cnt_r;
  logic        stale;

  assign stale    = (hold_r.time_start <= TIME + 64'(LEAD_CYCLES));
  assign DROP_CNT = drop_cnt_r;
`else
  logic unused_time;

  assign unused_time = ^TIME;
  assign DROP_CNT    = '0;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state                <= S_WAIT_FIFO;
      hold_r               <= '0;
      wr_data_r            <= 1'b0;
      mem_out_r            <= '0;
      mem_out_r.time_start <= '1;
`ifdef STALE_DROP_EN
      drop_cnt_r           <= '0;
`endif
    end else if (FLUSH) begin
      state                <= S_WAIT_FIFO;
      hold_r               <= '0;
      wr_data_r            <= 1'b0;
      mem_out_r            <= '0;
      mem_out_r.time_start <= '1;
`ifdef STALE_DROP_EN
      drop_cnt_r           <= '0;
`endif
    end else begin
      wr_data_r <= 1'b0;
      case (state)
        S_WAIT_FIFO: if (!empty_r) state <= S_POP;
        S_POP: begin
          hold_r <= fifo_mem[rd_ptr];
          state  <= S_CHECK;
        end
        S_CHECK: begin
`ifdef STALE_DROP_EN
          if (stale) begin
            if (drop_cnt_r != 16'hFFFF) drop_cnt_r <= drop_cnt_r + 16'd1;
            state <= S_WAIT_FIFO;
          end else begin
            wr_data_r <= 1'b1;
            mem_out_r <= hold_r;
            state     <= S_ISSUE;
          end
`else
          wr_data_r <= 1'b1;
          mem_out_r <= hold_r;
          state     <= S_ISSUE;
`endif
        end
        S_ISSUE: state <= S_ARMED;
        S_ARMED: if (req_rise) state <= S_RUN;
        S_RUN:   if (req_fall) state <= S_WAIT_FIFO;
        default: state <= S_WAIT_FIFO;
      endcase
    end
  end

  assign WR_DATA            = wr_data_r;
  assign MEM_DDS_freq       = mem_out_r.dds_freq;
  assign MEM_DDS_delta_freq = mem_out_r.dds_delta_freq;
  assign MEM_DDS_delta_rate = mem_out_r.dds_delta_rate;
  assign MEM_TIME_START     = mem_out_r.time_start;
  assign MEM_N_impuls       = mem_out_r.n_impuls;
  assign MEM_TYPE_impulse   = mem_out_r.type_impulse;
  assign MEM_Interval_Ti    = mem_out_r.interval_ti;
  assign MEM_Interval_Tp    = mem_out_r.interval_tp;
  assign MEM_Tblank1        = mem_out_r.tblank1;
  assign MEM_Tblank2        = mem_out_r.tblank2;
  assign FULL               = full_r;
  assign EMPTY              = empty_r;
  assign LEVEL              = level_r;
  assign OVF                = ovf_r;
  assign BUSY               = (state != S_WAIT_FIFO);

endmodule

// File: tb/tb_cmd_sched_queue.sv
// Scoreboard bench for cmd_sched_queue: expected issues are queued at write time and popped by a WR_DATA monitor.
module tb_cmd_sched_queue;

  typedef struct packed {
    logic [47:0] dds_freq;
    logic [47:0] dds_delta_freq;
    logic [31:0] dds_delta_rate;
    logic [63:0] time_start;
    logic [15:0] n_impuls;
    logic [1:0]  type_impulse;
    logic [31:0] interval_ti;
    logic [31:0] interval_tp;
    logic [31:0] tblank1;
    logic [31:0] tblank2;
  } cmd_t;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        FLUSH;
  logic        CMD_WR;
  cmd_t        cmd_drv;
  logic [63:0] sys_time;
  logic        REQ_COMMAND;
  logic        WR_DATA;
  logic [47:0] MEM_DDS_freq;
  logic [47:0] MEM_DDS_delta_freq;
  logic [31:0] MEM_DDS_delta_rate;
  logic [63:0] MEM_TIME_START;
  logic [15:0] MEM_N_impuls;
  logic [1:0]  MEM_TYPE_impulse;
  logic [31:0] MEM_Interval_Ti;
  logic [31:0] MEM_Interval_Tp;
  logic [31:0] MEM_Tblank1;
  logic [31:0] MEM_Tblank2;
  logic        FULL;
  logic        EMPTY;
  logic [3:0]  LEVEL;
  logic        OVF;
  logic [15:0] DROP_CNT;
  logic        BUSY;

  cmd_t mem_now;
  cmd_t idle_exp;
  cmd_t exp_c;
  cmd_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   issued_cnt = 0;
  int   done_cnt = 0;
  logic master_en = 1'b1;

  cmd_sched_queue #(.DEPTH(8), .LEAD_CYCLES(96)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .FLUSH(FLUSH), .CMD_WR(CMD_WR),
    .CMD_DDS_freq(cmd_drv.dds_freq), .CMD_DDS_delta_freq(cmd_drv.dds_delta_freq),
    .CMD_DDS_delta_rate(cmd_drv.dds_delta_rate), .CMD_TIME_START(cmd_drv.time_start),
    .CMD_N_impuls(cmd_drv.n_impuls), .CMD_TYPE_impulse(cmd_drv.type_impulse),
    .CMD_Interval_Ti(cmd_drv.interval_ti), .CMD_Interval_Tp(cmd_drv.interval_tp),
    .CMD_Tblank1(cmd_drv.tblank1), .CMD_Tblank2(cmd_drv.tblank2),
    .TIME(sys_time), .REQ_COMMAND(REQ_COMMAND), .WR_DATA(WR_DATA),
    .MEM_DDS_freq(MEM_DDS_freq), .MEM_DDS_delta_freq(MEM_DDS_delta_freq),
    .MEM_DDS_delta_rate(MEM_DDS_delta_rate), .MEM_TIME_START(MEM_TIME_START),
    .MEM_N_impuls(MEM_N_impuls), .MEM_TYPE_impulse(MEM_TYPE_impulse),
    .MEM_Interval_Ti(MEM_Interval_Ti), .MEM_Interval_Tp(MEM_Interval_Tp),
    .MEM_Tblank1(MEM_Tblank1), .MEM_Tblank2(MEM_Tblank2),
    .FULL(FULL), .EMPTY(EMPTY), .LEVEL(LEVEL), .OVF(OVF), .DROP_CNT(DROP_CNT), .BUSY(BUSY)
  );

  always #10 CLK = ~CLK;

  assign mem_now = {MEM_DDS_freq, MEM_DDS_delta_freq, MEM_DDS_delta_rate, MEM_TIME_START,
                    MEM_N_impuls, MEM_TYPE_impulse, MEM_Interval_Ti, MEM_Interval_Tp,
                    MEM_Tblank1, MEM_Tblank2};

  task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every WR_DATA must match the oldest expected command and follow the previous completion.
  always @(negedge CLK) begin
    if (RESET_N && WR_DATA) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious_wr_data: got issue of TIME_START=%0h expected no issue", MEM_TIME_START);
      end else begin
        exp_c = sb.pop_front();
        check("mem_fields", mem_now, exp_c);
      end
      check("issue_after_fall", issued_cnt - done_cnt, 0);
      issued_cnt++;
    end
  end

  // master_start model: start each issued command after a short delay, run it, then drop REQ_COMMAND.
  initial begin
    REQ_COMMAND = 1'b0;
    forever begin
      @(posedge CLK);
      if (master_en && issued_cnt > done_cnt) begin
        repeat ($urandom_range(1, 4)) @(posedge CLK);
        #1 REQ_COMMAND = 1'b1;
        repeat ($urandom_range(4, 12)) @(posedge CLK);
        #1 REQ_COMMAND = 1'b0;
        done_cnt++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic cmd_t rand_cmd(input logic [63:0] ts);
    cmd_t c;
    c.dds_freq       = {16'($urandom), $urandom};
    c.dds_delta_freq = {16'($urandom), $urandom};
    c.dds_delta_rate = $urandom;
    c.time_start     = ts;
    c.n_impuls       = 16'($urandom);
    c.type_impulse   = 2'($urandom);
    c.interval_ti    = $urandom;
    c.interval_tp    = $urandom;
    c.tblank1        = $urandom;
    c.tblank2        = $urandom;
    return c;
  endfunction

  task automatic write_cmd(input cmd_t c);
    cmd_drv = c;
    CMD_WR  = 1'b1;
    @(posedge CLK);
    #1 CMD_WR = 1'b0;
  endtask

  task automatic realign();
    @(posedge CLK);
    #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || issued_cnt != done_cnt || BUSY) && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    check(tag, sb.size(), 0);
    realign();
  endtask

  task automatic wait_issued(input int target, input string tag);
    int n = 0;
    while (issued_cnt < target && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check(tag, issued_cnt, target);
    realign();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wr_data"}, WR_DATA, 1'b0);
    check({tag, "_mem"}, mem_now, idle_exp);
    check({tag, "_level"}, LEVEL, 4'd0);
    check({tag, "_empty"}, EMPTY, 1'b1);
    check({tag, "_full"}, FULL, 1'b0);
    check({tag, "_busy"}, BUSY, 1'b0);
    check({tag, "_drop"}, DROP_CNT, 16'd0);
  endtask

  initial begin
    cmd_t c;
    int   n;
    int   base;
    int   drops_exp;
    idle_exp            = '0;
    idle_exp.time_start = '1;
    RESET_N  = 1'b0;
    FLUSH    = 1'b0;
    CMD_WR   = 1'b0;
    cmd_drv  = '0;
    sys_time = 64'd0;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_idle_outputs("reset");
    check("reset_ovf", OVF, 1'b0);
    RESET_N = 1'b1;
    realign();

    // Latency of a single command into an idle queue.
    c = rand_cmd(64'd5000);
    sb.push_back(c);
    write_cmd(c);
    n = 0;
    while (!WR_DATA && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("latency", n, 4);
    drain("drain_latency");

    // Three commands in order, each issued only after the previous completes.
    base = issued_cnt;
    foreach (c.time_start[i]) ;
    for (int i = 0; i < 3; i++) begin
      c = rand_cmd(64'(1000 + 4000 * i));
      sb.push_back(c);
      write_cmd(c);
    end
    drain("drain_seq3");
    check("seq3_count", issued_cnt - base, 3);

    // Random bursts that never exceed the queue depth.
    for (int b = 0; b < 6; b++) begin
      int nb = $urandom_range(1, 8);
      for (int i = 0; i < nb; i++) begin
        c = rand_cmd(64'(200 + $urandom_range(0, 1000000)));
        sb.push_back(c);
        write_cmd(c);
        repeat ($urandom_range(0, 3)) realign();
      end
      drain("drain_burst");
    end

    // Lead-time boundary: 1050 and 1096 are stale at TIME=1000, 1097 is not.
    sys_time = 64'd1000;
    realign();
    drops_exp = 0;
    for (int i = 0; i < 3; i++) begin
      logic [63:0] ts;
      ts = (i == 0) ? 64'd1050 : (i == 1) ? 64'd1096 : 64'd1097;
      c = rand_cmd(ts);
`ifdef STALE_DROP_EN
      if (ts <= sys_time + 64'd96) drops_exp++;
      else sb.push_back(c);
`else
      sb.push_back(c);
`endif
      write_cmd(c);
    end
    drain("drain_stale");
    check("stale_drop_cnt", DROP_CNT, 16'(drops_exp));
    sys_time = 64'd0;

    // Overflow: one command parked in ARMED, then nine writes; the ninth is lost.
    master_en = 1'b0;
    base = issued_cnt;
    c = rand_cmd(64'd50000);
    sb.push_back(c);
    write_cmd(c);
    wait_issued(base + 1, "ovf_first_issue");
    for (int i = 0; i < 9; i++) begin
      c = rand_cmd(64'(60000 + i));
      if (i < 8) sb.push_back(c);
      write_cmd(c);
    end
    check("ovf_full", FULL, 1'b1);
    check("ovf_level", LEVEL, 4'd8);
    check("ovf_flag", OVF, 1'b1);
    master_en = 1'b1;
    drain("drain_ovf");
    check("ovf_sticky", OVF, 1'b1);
    check("ovf_empty_after", EMPTY, 1'b1);
    FLUSH = 1'b1;
    realign();
    FLUSH = 1'b0;
    check("flush_clears_ovf", OVF, 1'b0);

    // Push into a full queue during the POP cycle is accepted and keeps order.
    master_en = 1'b0;
    base = issued_cnt;
    c = rand_cmd(64'd70000);
    sb.push_back(c);
    write_cmd(c);
    wait_issued(base + 1, "pp_first_issue");
    for (int i = 0; i < 8; i++) begin
      c = rand_cmd(64'(80000 + i));
      sb.push_back(c);
      write_cmd(c);
    end
    check("pp_level_before", LEVEL, 4'd8);
    master_en = 1'b1;
    n = 0;
    @(negedge CLK);
    while (BUSY && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("pp_wait_busy", BUSY, 1'b0);
    realign();
    c = rand_cmd(64'd90000);
    sb.push_back(c);
    write_cmd(c);
    check("pp_level_after", LEVEL, 4'd8);
    check("pp_ovf", OVF, 1'b0);
    drain("drain_pp");

    // FLUSH while ARMED with three queued; a simultaneous write is ignored.
    master_en = 1'b0;
    base = issued_cnt;
    for (int i = 0; i < 4; i++) begin
      c = rand_cmd(64'(100000 + i));
      if (i == 0) sb.push_back(c);
      write_cmd(c);
    end
    wait_issued(base + 1, "flush_first_issue");
    check("flush_level_before", LEVEL, 4'd3);
    cmd_drv = rand_cmd(64'd123456);
    CMD_WR  = 1'b1;
    FLUSH   = 1'b1;
    realign();
    CMD_WR  = 1'b0;
    FLUSH   = 1'b0;
    check_idle_outputs("flush");
    base = issued_cnt;
    master_en = 1'b1;
    n = 0;
    while (done_cnt != issued_cnt && n < 200) begin
      @(negedge CLK);
      n++;
    end
    repeat (20) @(negedge CLK);
    check("flush_no_issue", issued_cnt, base);
    realign();

    // Asynchronous reset in the middle of RUN.
    c = rand_cmd(64'd200000);
    sb.push_back(c);
    write_cmd(c);
    n = 0;
    while (!REQ_COMMAND && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("rst_req_seen", REQ_COMMAND, 1'b1);
    repeat (3) @(posedge CLK);
    #1 RESET_N = 1'b0;
    #1;
    check_idle_outputs("rst_mid_run");
    check("rst_mid_run_ovf", OVF, 1'b0);
    @(negedge CLK);
    RESET_N = 1'b1;
    n = 0;
    while (done_cnt != issued_cnt && n < 200) begin
      @(negedge CLK);
      n++;
    end
    repeat (5) @(negedge CLK);
    check("rst_idle_busy", BUSY, 1'b0);
    realign();
    c = rand_cmd(64'd300000);
    sb.push_back(c);
    write_cmd(c);
    drain("drain_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
